// File: rtl/audio_router_pkg.sv
// Shared FSM state codes and width helpers for the audio stream router.
package audio_router_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_PLAY     = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  function automatic int src_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  function automatic int ramp_steps(input int ramp_log2);
    return 1 << ramp_log2;
  endfunction

  // Gain counter spans 0..RAMP_STEPS inclusive, hence one extra bit.
  function automatic int gain_w(input int ramp_log2);
    return ramp_log2 + 1;
  endfunction

  function automatic int prod_w(input int data_w, input int ramp_log2);
    return data_w + ramp_log2 + 1;
  endfunction

endpackage

// File: rtl/audio_stream_router_gain.sv
// Per-channel gain stage: signed sample times ramp gain, floor-shifted, registered.
module audio_gain_stage
  import audio_router_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int RAMP_LOG2 = 6
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DATA_W-1:0]    sample,
  input  logic [RAMP_LOG2:0]   gain,
  output logic [DATA_W-1:0]    result
);

  localparam int PW = prod_w(DATA_W, RAMP_LOG2);

  logic signed [PW-1:0] smp_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic        [DATA_W-1:0] scaled;

  assign smp_ext  = {{(PW-DATA_W){sample[DATA_W-1]}}, sample};
  assign gain_ext = {{(PW-RAMP_LOG2-1){1'b0}}, gain};
  assign product  = smp_ext * gain_ext;
  // Arithmetic shift floors toward minus infinity; full gain is an exact pass-through.
  assign scaled   = DATA_W'(product >>> RAMP_LOG2);

  always_ff @(posedge clk) begin
    if (clear) begin
      result <= '0;
    end else if (load) begin
      result <= scaled;
    end
  end

endmodule

// File: rtl/audio_stream_router.sv
// Selects one of NUM_SRC PCM sources with a linear fade-out/fade-in on every switch.
// Optional stall watchdog in FADE_OUT enabled by defining AUDIO_ROUTER_STALL_TIMEOUT_EN.
module audio_stream_router
  import audio_router_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 24,
  parameter int RAMP_LOG2   = 6,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              run,
  input  logic [src_w(NUM_SRC)-1:0]         select,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC*NUM_CH*DATA_W-1:0]  src_data,
  output logic                              out_valid,
  output logic [NUM_CH*DATA_W-1:0]          out_data,
  output logic [src_w(NUM_SRC)-1:0]         active_src,
  output logic                              switching
);

  localparam int SEL_W = src_w(NUM_SRC);
  localparam int G_W   = gain_w(RAMP_LOG2);
  localparam logic [G_W-1:0] RAMP_MAX = G_W'(ramp_steps(RAMP_LOG2));

  logic [1:0]       state, state_nx;
  logic [G_W-1:0]   gain, gain_nx;
  logic [SEL_W-1:0] pending, pending_nx, active_nx;
  logic             strobe;
  logic             sel_ok;
  logic             stall_hit;
  logic             clear;
  logic [NUM_CH*DATA_W-1:0] src_frame;

  assign sel_ok    = int'(select) < NUM_SRC;
  assign strobe    = run && (state != ST_IDLE) && src_valid[active_src];
  assign switching = (state == ST_FADE_IN) || (state == ST_FADE_OUT);
  assign clear     = reset || !run;

`ifdef AUDIO_ROUTER_STALL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign stall_hit = (state == ST_FADE_OUT) && !strobe && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      wd_cnt <= '0;
    end else if ((state == ST_FADE_OUT) && !strobe && !stall_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    gain_nx    = gain;
    active_nx  = active_src;
    pending_nx = pending;
    case (state)
      ST_IDLE: begin
        if (sel_ok) active_nx = select;
        gain_nx  = '0;
        state_nx = ST_FADE_IN;
      end
      ST_FADE_IN, ST_PLAY: begin
        if (sel_ok && (select != active_src)) begin
          pending_nx = select;
          state_nx   = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        if (sel_ok) begin
          if (select == active_src) state_nx = ST_FADE_IN;
          else                      pending_nx = select;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Gain steps against the post-transition state so an abort reverses immediately.
    if ((state_nx == ST_FADE_IN) && strobe) begin
      if (gain != RAMP_MAX) gain_nx = gain + 1'b1;
      if (gain_nx == RAMP_MAX) state_nx = ST_PLAY;
    end else if (state_nx == ST_FADE_OUT) begin
      if (strobe && (gain != '0)) gain_nx = gain - 1'b1;
      if ((gain_nx == '0) || stall_hit) begin
        gain_nx   = '0;
        active_nx = pending_nx;
        state_nx  = ST_FADE_IN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gain       <= '0;
      active_src <= '0;
      pending    <= '0;
      out_valid  <= 1'b0;
    end else if (!run) begin
      state     <= ST_IDLE;
      gain      <= '0;
      out_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      gain       <= gain_nx;
      active_src <= active_nx;
      pending    <= pending_nx;
      out_valid  <= strobe;
    end
  end

  always_comb begin
    src_frame = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (active_src == SEL_W'(s)) src_frame = src_data[s*NUM_CH*DATA_W +: NUM_CH*DATA_W];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    audio_gain_stage #(
      .DATA_W    (DATA_W),
      .RAMP_LOG2 (RAMP_LOG2)
    ) u_gain (
      .clk    (clk),
      .clear  (clear),
      .load   (strobe),
      .sample (src_frame[c*DATA_W +: DATA_W]),
      .gain   (gain),
      .result (out_data[c*DATA_W +: DATA_W])
    );
  end

endmodule
